ahb_master_arbiter: RTL and testbench

AHB_MASTER_ARBITER -- requirements
Module: ahb_master_arbiter

---
 rtl/ahb_master_arbiter.sv | 126 ++++++++++++
 tb/tb_ahb_master_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter: m0 (instruction cache) and m1 (data side) share one master port.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise m0 wins every tie.
module ahb_master_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [ADDR_W-1:0] m0_haddr,
  input  logic [1:0]        m0_htrans,
  input  logic [2:0]        m0_hsize,
  input  logic              m0_hwrite,
  input  logic [31:0]       m0_hwdata,
  output logic              m0_hready,
  output logic [31:0]       m0_hrdata,
  input  logic [ADDR_W-1:0] m1_haddr,
  input  logic [1:0]        m1_htrans,
  input  logic [2:0]        m1_hsize,
  input  logic              m1_hwrite,
  input  logic [31:0]       m1_hwdata,
  output logic              m1_hready,
  output logic [31:0]       m1_hrdata,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic [2:0]        HSIZE,
  output logic              HWRITE,
  output logic [31:0]       HWDATA,
  input  logic [31:0]       HRDATA,
  input  logic              HREADY,
  output logic              arb_owner,
  output logic              arb_busy
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  logic       sel;
  logic       sel_q;
  logic       owner_valid;
  logic       dp_owner;
  logic       dp_valid;
  logic       tie_winner;
  logic       req0;
  logic       req1;
  logic [1:0] own_trans;
  logic [1:0] fwd_trans;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_ptr;

  assign tie_winner = rr_ptr;

  // Pointer names the master that lost the most recent change of ownership.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      rr_ptr <= 1'b0;
    end else if (HREADY && (sel != sel_q)) begin
      rr_ptr <= ~sel;
    end
  end
`else
  assign tie_winner = 1'b0;
`endif

  always_comb begin
    req0      = (m0_htrans == TR_NONSEQ);
    req1      = (m1_htrans == TR_NONSEQ);
    own_trans = sel_q ? m1_htrans : m0_htrans;
    sel       = sel_q;
    if (!HREADY) begin
      sel = sel_q;
    end else if (owner_valid && (own_trans != TR_IDLE)) begin
      sel = sel_q;
    end else if (req0 && req1) begin
      sel = tie_winner;
    end else if (req0) begin
      sel = 1'b0;
    end else if (req1) begin
      sel = 1'b1;
    end
    fwd_trans = sel ? m1_htrans : m0_htrans;
  end

  // sel_q only moves when HREADY is high, since sel falls back to sel_q otherwise.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      sel_q       <= 1'b0;
      owner_valid <= 1'b0;
      dp_owner    <= 1'b0;
      dp_valid    <= 1'b0;
    end else begin
      sel_q <= sel;
      if (HREADY) begin
        owner_valid <= (fwd_trans != TR_IDLE);
        dp_owner    <= sel;
        dp_valid    <= fwd_trans[1];
      end
    end
  end

  always_comb begin
    HADDR     = '0;
    HTRANS    = TR_IDLE;
    HSIZE     = 3'b000;
    HWRITE    = 1'b0;
    HWDATA    = 32'h0;
    arb_owner = 1'b0;
    arb_busy  = 1'b0;
    m0_hready = HREADY;
    m1_hready = HREADY;
    m0_hrdata = HRDATA;
    m1_hrdata = HRDATA;
    if (HRESETn) begin
      HADDR     = sel ? m1_haddr  : m0_haddr;
      HTRANS    = fwd_trans;
      HSIZE     = sel ? m1_hsize  : m0_hsize;
      HWRITE    = sel ? m1_hwrite : m0_hwrite;
      HWDATA    = dp_valid ? (dp_owner ? m1_hwdata : m0_hwdata) : 32'h0;
      arb_owner = sel;
      arb_busy  = (fwd_trans != TR_IDLE);
      // A master with a pending request that is neither addressed nor in its data phase is stalled.
      m0_hready = ((dp_valid && !dp_owner) || !sel || (m0_htrans == TR_IDLE)) ? HREADY : 1'b0;
      m1_hready = ((dp_valid && dp_owner) || sel || (m1_htrans == TR_IDLE)) ? HREADY : 1'b0;
    end
  end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter in its default (fixed-priority) build.
module tb_ahb_master_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] m0_haddr, m1_haddr;
  logic [1:0]  m0_htrans, m1_htrans;
  logic [2:0]  m0_hsize, m1_hsize;
  logic        m0_hwrite, m1_hwrite;
  logic [31:0] m0_hwdata, m1_hwdata;
  logic        m0_hready, m1_hready;
  logic [31:0] m0_hrdata, m1_hrdata;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        arb_owner;
  logic        arb_busy;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [1:0] IDLE = 2'b00, NSEQ = 2'b10, SEQ = 2'b11;

  ahb_master_arbiter #(.ADDR_W(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hsize(m0_hsize),
    .m0_hwrite(m0_hwrite), .m0_hwdata(m0_hwdata), .m0_hready(m0_hready), .m0_hrdata(m0_hrdata),
    .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hsize(m1_hsize),
    .m1_hwrite(m1_hwrite), .m1_hwdata(m1_hwdata), .m1_hready(m1_hready), .m1_hrdata(m1_hrdata),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .arb_owner(arb_owner), .arb_busy(arb_busy)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic m0_drv(input logic [1:0] tr, input logic [31:0] a, input logic [31:0] wd);
    m0_htrans = tr;
    m0_haddr  = a;
    m0_hwdata = wd;
  endtask

  task automatic m1_drv(input logic [1:0] tr, input logic [31:0] a, input logic [31:0] wd);
    m1_htrans = tr;
    m1_haddr  = a;
    m1_hwdata = wd;
  endtask

  // Advance one clock and step just past the edge; checks then run #2 after new inputs.
  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESETn   = 1'b0;
    HREADY    = 1'b1;
    HRDATA    = 32'h0;
    m0_hsize  = 3'b010;
    m1_hsize  = 3'b010;
    m0_hwrite = 1'b0;
    m1_hwrite = 1'b1;
    m0_drv(IDLE, 32'h0, 32'h0);
    m1_drv(NSEQ, 32'h55, 32'h77);
    #2;
    chk("rst_htrans", {30'h0, HTRANS}, 32'h0);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwrite", {31'h0, HWRITE}, 32'h0);
    chk("rst_owner", {31'h0, arb_owner}, 32'h0);
    chk("rst_busy", {31'h0, arb_busy}, 32'h0);
    chk("rst_m0_hready", {31'h0, m0_hready}, 32'h1);
    chk("rst_m1_hready", {31'h0, m1_hready}, 32'h1);
    cyc();
    cyc();
    HRESETn = 1'b1;
    m1_drv(IDLE, 32'h0, 32'h0);

    // uncontended read, same-cycle forwarding
    m0_drv(NSEQ, 32'h100, 32'h0);
    #2;
    chk("t1_haddr", HADDR, 32'h100);
    chk("t1_htrans", {30'h0, HTRANS}, 32'h2);
    chk("t1_owner", {31'h0, arb_owner}, 32'h0);
    chk("t1_m0_hready", {31'h0, m0_hready}, 32'h1);
    chk("t1_hwrite", {31'h0, HWRITE}, 32'h0);
    chk("t1_hsize", {29'h0, HSIZE}, 32'h2);
    cyc();
    m0_drv(IDLE, 32'h0, 32'h0);
    HRDATA = 32'hDEADBEEF;
    #2;
    chk("t1_m0_hrdata", m0_hrdata, 32'hDEADBEEF);
    chk("t1_m1_hrdata", m1_hrdata, 32'hDEADBEEF);
    chk("t1_idle", {30'h0, HTRANS}, 32'h0);
    cyc();

    // simultaneous requests, handover with overlapping data phase
    m0_drv(NSEQ, 32'h200, 32'hA0A0);
    m1_drv(NSEQ, 32'h8000, 32'hB1B1);
    #2;
    chk("t2_haddr", HADDR, 32'h200);
    chk("t2_owner", {31'h0, arb_owner}, 32'h0);
    chk("t2_m1_stall", {31'h0, m1_hready}, 32'h0);
    chk("t2_m0_hready", {31'h0, m0_hready}, 32'h1);
    cyc();
    m0_drv(IDLE, 32'h0, 32'hA0A0);
    #2;
    chk("t2_handover_addr", HADDR, 32'h8000);
    chk("t2_handover_owner", {31'h0, arb_owner}, 32'h1);
    chk("t2_overlap_wdata", HWDATA, 32'hA0A0);
    chk("t2_hwrite", {31'h0, HWRITE}, 32'h1);
    chk("t2_m1_hready", {31'h0, m1_hready}, 32'h1);
    cyc();
    m1_drv(IDLE, 32'h0, 32'hB1B1);
    #2;
    chk("t2_m1_wdata", HWDATA, 32'hB1B1);
    chk("t2_idle_busy", {31'h0, arb_busy}, 32'h0);
    cyc();
    m0_drv(NSEQ, 32'h204, 32'hC3C3);
    m1_drv(NSEQ, 32'h8004, 32'h0);
    #2;
    chk("t2_tie_owner", {31'h0, arb_owner}, 32'h0);
    chk("t2_tie_addr", HADDR, 32'h204);
    chk("t2_tie_m1_stall", {31'h0, m1_hready}, 32'h0);
    cyc();
    m0_drv(IDLE, 32'h0, 32'hC3C3);
    m1_drv(IDLE, 32'h0, 32'h0);
    #2;
    chk("t2_tie_wdata", HWDATA, 32'hC3C3);
    cyc();

    // fixed priority: m0 wins every tie even after m1 has owned the bus
    for (int i = 0; i < 3; i++) begin
      m1_drv(NSEQ, 32'h9000 + i, 32'h0);
      #2;
      chk("t3_m1_alone", {31'h0, arb_owner}, 32'h1);
      cyc();
      m1_drv(IDLE, 32'h0, 32'h0);
      cyc();
      m0_drv(NSEQ, 32'h500 + 4 * i, 32'h0);
      m1_drv(NSEQ, 32'h9100 + i, 32'h0);
      #2;
      chk("t3_tie_owner", {31'h0, arb_owner}, 32'h0);
      chk("t3_tie_addr", HADDR, 32'h500 + 4 * i);
      cyc();
      m0_drv(IDLE, 32'h0, 32'h0);
      m1_drv(IDLE, 32'h0, 32'h0);
      cyc();
    end

    // m0 burst is not interrupted by m1
    m0_drv(NSEQ, 32'h300, 32'h0);
    #2;
    chk("t4_beat0", HADDR, 32'h300);
    cyc();
    for (int i = 1; i < 4; i++) begin
      m0_drv(SEQ, 32'h300 + 4 * i, 32'h0);
      m1_drv(NSEQ, 32'hA000, 32'h0);
      #2;
      chk("t4_beat_addr", HADDR, 32'h300 + 4 * i);
      chk("t4_beat_trans", {30'h0, HTRANS}, 32'h3);
      chk("t4_beat_owner", {31'h0, arb_owner}, 32'h0);
      chk("t4_m1_stall", {31'h0, m1_hready}, 32'h0);
      cyc();
    end
    m0_drv(IDLE, 32'h0, 32'h0);
    #2;
    chk("t4_m1_addr", HADDR, 32'hA000);
    chk("t4_m1_owner", {31'h0, arb_owner}, 32'h1);
    cyc();
    m1_drv(IDLE, 32'h0, 32'h0);
    #2;
    chk("t4_idle", {30'h0, HTRANS}, 32'h0);
    cyc();

    // wait states freeze the address phase
    m0_drv(NSEQ, 32'h400, 32'h0);
    #2;
    chk("t5_addr", HADDR, 32'h400);
    cyc();
    HREADY = 1'b0;
    m1_drv(NSEQ, 32'hB000, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("t5_frozen_addr", HADDR, 32'h400);
      chk("t5_frozen_owner", {31'h0, arb_owner}, 32'h0);
      chk("t5_m1_stall", {31'h0, m1_hready}, 32'h0);
      cyc();
    end
    HREADY = 1'b1;
    m0_drv(IDLE, 32'h0, 32'h0);
    #2;
    chk("t5_release_addr", HADDR, 32'hB000);
    cyc();
    m1_drv(IDLE, 32'h0, 32'h0);
    cyc();

    // reset in the middle of an m1 burst
    m1_drv(NSEQ, 32'hC000, 32'h0);
    cyc();
    m1_drv(SEQ, 32'hC004, 32'h22);
    #2;
    chk("t6_beat1_wdata", HWDATA, 32'h22);
    cyc();
    m1_drv(SEQ, 32'hC008, 32'h33);
    HRESETn = 1'b0;
    #2;
    chk("t6_rst_htrans", {30'h0, HTRANS}, 32'h0);
    chk("t6_rst_hwdata", HWDATA, 32'h0);
    cyc();
    HRESETn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m1_drv(SEQ, 32'hC00C, 32'h44);
      #2;
      chk("t6_post_htrans", {30'h0, HTRANS}, 32'h0);
      chk("t6_post_hwdata", HWDATA, 32'h0);
      chk("t6_post_busy", {31'h0, arb_busy}, 32'h0);
      chk("t6_post_m1_stall", {31'h0, m1_hready}, 32'h0);
      cyc();
    end
    m1_drv(NSEQ, 32'hD000, 32'h55);
    #2;
    chk("t6_regrant_addr", HADDR, 32'hD000);
    chk("t6_regrant_owner", {31'h0, arb_owner}, 32'h1);
    chk("t6_regrant_hwdata", HWDATA, 32'h0);
    cyc();
    m1_drv(IDLE, 32'h0, 32'h55);
    #2;
    chk("t6_dp_wdata", HWDATA, 32'h55);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
